phased_pwm_array: RTL and testbench

Multi-channel burst PWM generator for the ultrasonic transmit array. It drives NUM_CHANNELS square waves at a common period, each shifted by its own phase offset, for beam steering. Bursts run for a programmed number of periods, or continuously until stopped. The controller sets duty, phases and burst length and fires `start_in`; the block reports `busy_out` and `done_out`. Its outputs feed the transducer driver pins directly.

---
 rtl/pwm_pkg.sv | 20 ++
 rtl/phase_channel.sv | 27 ++
 rtl/phased_pwm_array.sv | 103 ++++++++++
 tb/tb_phased_pwm_array.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the phased PWM array.
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Both operands are already below period, so one conditional subtract
  // fully reduces the sum.
  function automatic logic [31:0] wrap_add(input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic [31:0] period);
    logic [31:0] s;
    s = a + b;
    if (s >= period) s = s - period;
    return s;
  endfunction

endpackage

// File: rtl/phase_channel.sv
// One transducer channel: rotates the master count by its phase and
// compares against duty to produce a registered PWM bit.
module phase_channel
  import pwm_pkg::*;
#(
  parameter int PERIOD = 2500,
  parameter int CW     = $clog2(PERIOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [CW-1:0] cnt,
  input  logic [CW-1:0] phase,
  input  logic [CW-1:0] duty,
  input  logic          run,
  output logic          sig
);

  logic [31:0] chan_cnt;

  assign chan_cnt = wrap_add(32'(cnt), 32'(phase), 32'(PERIOD));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sig <= 1'b0;
    else     sig <= run & (chan_cnt < 32'(duty));
  end

endmodule

// File: rtl/phased_pwm_array.sv
// Burst PWM controller: FSM, master/period counters, shadow registers and
// a bank of phase-shifted channels sharing one carrier period.
module phased_pwm_array
  import pwm_pkg::*;
#(
  parameter  int NUM_CHANNELS           = 8,
  parameter  int PERIOD_IN_CLOCK_CYCLES = 2500,
  parameter  int MAX_BURST              = 255,
  localparam int CW                     = $clog2(PERIOD_IN_CLOCK_CYCLES),
  localparam int BW                     = $clog2(MAX_BURST + 1)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic [CW-1:0]              duty_in,
  input  logic [NUM_CHANNELS*CW-1:0] phase_in,
  input  logic [BW-1:0]              burst_len_in,
  input  logic                       start_in,
  input  logic                       stop_in,
  output logic                       busy_out,
  output logic                       done_out,
  output logic [NUM_CHANNELS-1:0]    sig_out
);

  localparam int            P    = PERIOD_IN_CLOCK_CYCLES;
  localparam logic [CW-1:0] LAST = CW'(P - 1);

  state_e                             state;
  logic [CW-1:0]                      m;
  logic [BW-1:0]                      n;
  logic [CW-1:0]                      duty_q;
  logic [BW-1:0]                      len_q;
  logic [NUM_CHANNELS-1:0][CW-1:0]    phase_q;
  logic [NUM_CHANNELS-1:0][CW-1:0]    phase_clamped;
  logic                               stop_pend;
  logic                               burst_end;
  logic                               run;

  // Compared one bit wider so a power-of-two period still clamps correctly.
  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    assign phase_clamped[k] =
      ({1'b0, phase_in[k*CW +: CW]} >= (CW+1)'(P)) ? LAST : phase_in[k*CW +: CW];

    phase_channel #(.PERIOD(P), .CW(CW)) u_ch (
      .clk   (clk_in),
      .rst   (rst_in),
      .cnt   (m),
      .phase (phase_q[k]),
      .duty  (duty_q),
      .run   (run),
      .sig   (sig_out[k])
    );
  end

  assign run       = (state == RUN);
  assign burst_end = ((len_q != '0) && (n == len_q - BW'(1))) || stop_pend || stop_in;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state     <= IDLE;
      m         <= '0;
      n         <= '0;
      duty_q    <= '0;
      len_q     <= '0;
      phase_q   <= '0;
      stop_pend <= 1'b0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        IDLE: begin
          if (start_in) begin
            state     <= RUN;
            busy_out  <= 1'b1;
            duty_q    <= duty_in;
            phase_q   <= phase_clamped;
            len_q     <= burst_len_in;
            m         <= '0;
            n         <= '0;
            stop_pend <= 1'b0;
          end
        end
        RUN: begin
          if (stop_in) stop_pend <= 1'b1;
          // Bursts only end on a period boundary so every channel sees whole periods.
          if (m == LAST) begin
            m <= '0;
            n <= n + BW'(1);
            if (burst_end) begin
              state    <= IDLE;
              busy_out <= 1'b0;
              done_out <= 1'b1;
            end
          end else begin
            m <= m + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phased_pwm_array.sv
// Randomized and directed checks of phased_pwm_array against a
// time-since-start reference model.
module tb_phased_pwm_array;

  localparam int NCH = 4;
  localparam int P   = 10;
  localparam int CW  = 4;
  localparam int BW  = 8;

  logic                 clk_in = 1'b0;
  logic                 rst_in;
  logic [CW-1:0]        duty_in;
  logic [NCH*CW-1:0]    phase_in;
  logic [BW-1:0]        burst_len_in;
  logic                 start_in;
  logic                 stop_in;
  logic                 busy_out;
  logic                 done_out;
  logic [NCH-1:0]       sig_out;

  always #5 clk_in = ~clk_in;

  phased_pwm_array #(
    .NUM_CHANNELS           (NCH),
    .PERIOD_IN_CLOCK_CYCLES (P),
    .MAX_BURST              (255)
  ) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .duty_in      (duty_in),
    .phase_in     (phase_in),
    .burst_len_in (burst_len_in),
    .start_in     (start_in),
    .stop_in      (stop_in),
    .busy_out     (busy_out),
    .done_out     (done_out),
    .sig_out      (sig_out)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: burst described by cycles elapsed since start (t), with the
  // carrier position being t mod P.
  bit             m_run = 0;
  int             m_t, m_duty, m_len;
  int             m_ph[NCH];
  bit             m_sp;
  bit             e_busy = 0, e_done = 0;
  logic [NCH-1:0] e_sig = '0;
  int             busy_cnt;
  int             hi_cnt[NCH];

  task automatic model_reset();
    m_run = 0; e_busy = 0; e_done = 0; e_sig = '0;
  endtask

  task automatic model_edge();
    logic [NCH-1:0] ns;
    for (int k = 0; k < NCH; k++)
      ns[k] = m_run && ((((m_t % P) + m_ph[k]) % P) < m_duty);
    e_done = 0;
    if (!m_run) begin
      if (start_in) begin
        m_run  = 1; m_t = 0; m_sp = 0;
        m_duty = int'(duty_in);
        m_len  = int'(burst_len_in);
        for (int k = 0; k < NCH; k++) begin
          int v;
          v = int'(phase_in[k*CW +: CW]);
          m_ph[k] = (v >= P) ? P - 1 : v;
        end
      end
    end else begin
      if (stop_in) m_sp = 1;
      if ((m_t % P == P - 1) && ((m_len != 0 && m_t == m_len * P - 1) || m_sp)) begin
        m_run = 0; e_done = 1;
      end else begin
        m_t++;
      end
    end
    e_busy = m_run;
    e_sig  = ns;
  endtask

  task automatic cycle(input bit s, input bit p);
    @(negedge clk_in);
    start_in = s; stop_in = p;
    model_edge();
    @(posedge clk_in); #1;
    chk("busy", 32'(busy_out), 32'(e_busy));
    chk("done", 32'(done_out), 32'(e_done));
    chk("sig",  32'(sig_out),  32'(e_sig));
    if (busy_out) busy_cnt++;
    for (int k = 0; k < NCH; k++) if (sig_out[k]) hi_cnt[k]++;
  endtask

  // Starts a burst and runs it to its done cycle (returns while done is high).
  task automatic run_burst(input int d, input logic [NCH*CW-1:0] ph, input int len,
                           input int stop_at, input bit perturb, input bit sws);
    int guard;
    duty_in = CW'(d); phase_in = ph; burst_len_in = BW'(len);
    busy_cnt = 0;
    for (int k = 0; k < NCH; k++) hi_cnt[k] = 0;
    cycle(1, sws);
    guard = 0;
    while (!e_done && guard < 4000) begin
      bit sp, st;
      sp = m_run && (m_t == stop_at);
      st = 0;
      if (perturb) begin
        duty_in  = CW'($urandom);
        phase_in = (NCH*CW)'($urandom);
        st       = 1'($urandom_range(0, 1));
      end
      cycle(st, sp);
      guard++;
    end
    if (!e_done) chk("burst_timeout", 0, 1);
  endtask

  task automatic chk_counts(input string tag, input int len, input int d);
    chk({tag, "_busy_len"}, busy_cnt, len * P);
    for (int k = 0; k < NCH; k++)
      chk({tag, "_high"}, hi_cnt[k], len * ((d > P) ? P : d));
  endtask

  localparam logic [NCH*CW-1:0] PH_A = {4'd9, 4'd5, 4'd2, 4'd0};
  localparam logic [NCH*CW-1:0] PH_B = {4'd8, 4'd3, 4'd7, 4'd1};

  initial begin
    rst_in = 1; start_in = 0; stop_in = 0;
    duty_in = '0; phase_in = '0; burst_len_in = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    chk("rst_busy", 32'(busy_out), 0);
    chk("rst_done", 32'(done_out), 0);
    chk("rst_sig",  32'(sig_out),  0);
    @(negedge clk_in); rst_in = 0;

    // Basic burst, L=3.
    run_burst(5, PH_A, 3, -1, 0, 0);
    chk_counts("burst", 3, 5);
    cycle(0, 0);

    // Continuous, stop pulsed at m=3 of the second period.
    run_burst(5, PH_A, 0, 13, 0, 0);
    chk("stop_busy_len", busy_cnt, 20);
    cycle(0, 0);

    // Inputs and start perturbed during RUN must not matter.
    run_burst(3, PH_B, 2, -1, 1, 0);
    chk_counts("freeze", 2, 3);
    cycle(0, 0);

    // Duty extremes and phase clamp.
    run_burst(0, PH_A, 2, -1, 0, 0);
    chk_counts("duty0", 2, 0);
    cycle(0, 0);
    run_burst(10, PH_A, 2, -1, 0, 0);
    chk_counts("duty10", 2, 10);
    cycle(0, 0);
    run_burst(4, {4'd9, 4'd12, 4'd9, 4'd15}, 1, -1, 0, 0);
    chk_counts("phclamp", 1, 4);
    cycle(0, 0);

    // Asynchronous reset at m=4.
    duty_in = 4'd5; phase_in = PH_A; burst_len_in = 8'd3;
    cycle(1, 0);
    repeat (4) cycle(0, 0);
    #2 rst_in = 1;
    #1;
    chk("arst_busy", 32'(busy_out), 0);
    chk("arst_done", 32'(done_out), 0);
    chk("arst_sig",  32'(sig_out),  0);
    model_reset();
    @(negedge clk_in); rst_in = 0;
    run_burst(5, PH_A, 1, -1, 0, 0);
    chk_counts("post_rst", 1, 5);

    // Back-to-back: second start lands in the done cycle.
    run_burst(6, PH_B, 2, -1, 0, 0);
    chk_counts("b2b", 2, 6);
    cycle(0, 0);

    // Stop in IDLE ignored; start+stop together keeps start.
    cycle(0, 1);
    cycle(0, 1);
    run_burst(7, PH_A, 2, -1, 0, 1);
    chk_counts("st_sp", 2, 7);
    cycle(0, 0);

    // Randomized bursts.
    for (int it = 0; it < 30; it++) begin
      int d, len, sa;
      bit pt, sws;
      d   = $urandom_range(0, 15);
      len = $urandom_range(0, 4);
      if (len == 0) sa = $urandom_range(0, 35);
      else          sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, len * P) : -1;
      pt  = 1'($urandom_range(0, 1));
      sws = 1'($urandom_range(0, 1));
      run_burst(d, (NCH*CW)'($urandom), len, sa, pt, sws);
      if (sa < 0 && !sws) chk_counts("rand", len, d);
      repeat ($urandom_range(0, 3)) cycle(0, 1'($urandom_range(0, 1)));
    end
    cycle(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
